// File: rtl/prog_cntr_pkg.sv
// Shared defaults and encodings for the programmable modulus counter.
// Also provides the parameter legality check used at elaboration.
package prog_cntr_pkg;

    localparam int unsigned     DEF_BITS     = 8;
    localparam longint unsigned DEF_MODULUS  = 64'd1 << DEF_BITS;
    localparam int unsigned     DEF_PRESCALE = 1;

    // Direction and boundary-mode encodings for the up and sat inputs
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;
    localparam logic SAT  = 1'b1;
    localparam logic WRAP = 1'b0;

    function automatic logic params_ok(input int unsigned     bits,
                                       input longint unsigned modulus,
                                       input int unsigned     prescale);
        return (bits >= 1) && (bits <= 32) &&
               (modulus >= 2) && (modulus <= (64'd1 << bits)) &&
               (prescale >= 1) && (prescale <= 65535);
    endfunction

endpackage

// File: rtl/prog_cntr_prescaler.sv
// cntr_prescaler: counts enabled cycles and ticks on every PRESCALE-th one.
// Only instantiated by prog_cntr when PROG_CNTR_PRESCALE_EN is defined.
module cntr_prescaler
    import prog_cntr_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = enable && w_last;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (enable) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/prog_cntr.sv
// prog_cntr: up/down modulus counter with wrap or saturate boundary behaviour.
// Define PROG_CNTR_PRESCALE_EN to insert a PRESCALE-cycle prescaler on the step path.
module prog_cntr
    import prog_cntr_pkg::*;
#(
    parameter int unsigned     BITS     = DEF_BITS,
    parameter longint unsigned MODULUS  = 64'd1 << BITS,
    parameter int unsigned     PRESCALE = DEF_PRESCALE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            enable,
    input  logic            up,
    input  logic            sat,
    output logic [BITS-1:0] q,
    output logic            full,
    output logic            empty,
    output logic            tc,
    output logic            sat_hit
);

    if (!params_ok(BITS, MODULUS, PRESCALE)) begin : g_bad_params
        $error("prog_cntr: illegal BITS/MODULUS/PRESCALE combination");
    end

    localparam logic [BITS-1:0] MAX_Q = BITS'(MODULUS - 64'd1);

    logic [BITS-1:0] r_q;
    logic            r_tc;
    logic            r_sat_hit;
    logic [BITS-1:0] w_q_nxt;
    logic            w_tc_nxt;
    logic            w_sat_hit_nxt;
    logic            w_tick;
    logic            w_step;
    logic            w_at_max;
    logic            w_at_zero;

`ifdef PROG_CNTR_PRESCALE_EN
    logic w_pre_clr;
    assign w_pre_clr = clear | load;

    cntr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_pre_clr),
        .enable (enable),
        .tick   (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    assign w_at_max  = (r_q == MAX_Q);
    assign w_at_zero = (r_q == '0);
    assign w_step    = enable && w_tick && !clear && !load;

    always_comb begin
        w_q_nxt       = r_q;
        w_tc_nxt      = 1'b0;
        w_sat_hit_nxt = r_sat_hit;
        if (clear) begin
            w_q_nxt       = '0;
            w_sat_hit_nxt = 1'b0;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the count range
            w_q_nxt       = (load_val > MAX_Q) ? MAX_Q : load_val;
            w_sat_hit_nxt = 1'b0;
        end else if (w_step) begin
            if (up == UP) begin
                if (!w_at_max) begin
                    w_q_nxt = r_q + BITS'(1);
                end else if (sat == SAT) begin
                    w_sat_hit_nxt = 1'b1;
                end else begin
                    w_q_nxt  = '0;
                    w_tc_nxt = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_q_nxt = r_q - BITS'(1);
                end else if (sat == SAT) begin
                    w_sat_hit_nxt = 1'b1;
                end else begin
                    w_q_nxt  = MAX_Q;
                    w_tc_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            r_tc      <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            r_q       <= w_q_nxt;
            r_tc      <= w_tc_nxt;
            r_sat_hit <= w_sat_hit_nxt;
        end
    end

    assign q       = r_q;
    assign tc      = r_tc;
    assign sat_hit = r_sat_hit;
    assign full    = w_at_max;
    assign empty   = w_at_zero;

endmodule
